// File: rtl/uncache_agent_if.sv
// Request/response and AXI single-beat channel bundle for the uncached access agent.
interface uncache_agent_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // pipeline request / response
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_W-1:0]     req_addr;
  logic [1:0]            req_size;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  busy;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  // read address / data
  logic                  arvalid;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arsize;
  logic                  arready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  rready;
  // write address / data / response
  logic                  awvalid;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awsize;
  logic                  awready;
  logic                  wvalid;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  wready;
  logic                  bvalid;
  logic                  bready;

  // agent side: accepts pipeline requests and masters the bus
  modport master (
    input  req_valid, req_wr, req_addr, req_size, req_wdata, req_wstrb,
    output req_ready, busy, resp_valid, resp_rdata,
    output arvalid, araddr, arsize, input arready,
    input  rvalid, rdata, output rready,
    output awvalid, awaddr, awsize, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, output bready
  );

  // environment side: MEM stage plus the bus slave
  modport slave (
    output req_valid, req_wr, req_addr, req_size, req_wdata, req_wstrb,
    input  req_ready, busy, resp_valid, resp_rdata,
    input  arvalid, araddr, arsize, output arready,
    output rvalid, rdata, input rready,
    input  awvalid, awaddr, awsize, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, input bready
  );
endinterface

// File: rtl/uncache_agent.sv
// Single-beat uncached load/store engine for the MEM stage (AXI-style master).
module uncache_agent #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           resetn,
  uncache_agent_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q, phys_addr;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_done, w_done;
  logic                accept, aw_hs, w_hs;

  // kseg0/kseg1 fold onto physical space by clearing the top three bits
  always_comb begin
    phys_addr = bus.req_addr;
    if (bus.req_addr[31:30] == 2'b10) phys_addr[31:29] = 3'b000;
  end

  assign accept = (state == IDLE) && bus.req_valid;
  assign aw_hs  = (state == WR_REQ) && !aw_done && bus.awready;
  assign w_hs   = (state == WR_REQ) && !w_done && bus.wready;

  // payload outputs come only from captured registers
  assign bus.araddr     = addr_q;
  assign bus.awaddr     = addr_q;
  assign bus.arsize     = {1'b0, size_q};
  assign bus.awsize     = {1'b0, size_q};
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.resp_rdata = rdata_q;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // capture the request on acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= phys_addr;
      size_q  <= bus.req_size;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
    end
  end

  // load data is held until the next load completes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            rdata_q <= '0;
    else if (state == RD_DATA && bus.rvalid) rdata_q <= bus.rdata;
  end

  // AW and W complete independently; flags clear once back in IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    bus.awvalid    = 1'b0;
    bus.wvalid     = 1'b0;
    bus.wlast      = 1'b0;
    bus.bready     = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_nxt = bus.req_wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        bus.rready = 1'b1;
        if (bus.rvalid) state_nxt = DONE;
      end
      WR_REQ: begin
        bus.awvalid = !aw_done;
        bus.wvalid  = !w_done;
        bus.wlast   = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) state_nxt = DONE;
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uncache_agent.sv
// Self-checking bench for uncache_agent: directed table, reset sequence, random traffic.
module tb_uncache_agent;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  uncache_agent_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  uncache_agent #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int unsigned ar_d, r_d, aw_d, w_d, b_d;
    bit          noise;
    bit          hold_req;
    logic [31:0] exp_addr;
    int unsigned exp_lat;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [1:0] size, logic [31:0] wdata,
                              logic [3:0] wstrb, logic [31:0] rdata, int unsigned ar_d,
                              int unsigned r_d, int unsigned aw_d, int unsigned w_d,
                              int unsigned b_d, bit noise, bit hold_req,
                              logic [31:0] exp_addr, int unsigned exp_lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.wstrb = wstrb;
    v.rdata = rdata; v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d;
    v.noise = noise; v.hold_req = hold_req; v.exp_addr = exp_addr; v.exp_lat = exp_lat;
    return v;
  endfunction

  // reference: kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) map modulo 512 MiB
  function automatic logic [31:0] model_phys(logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a % 32'h2000_0000;
    return a;
  endfunction

  // reference: 3 cycles minimum plus every cycle the slave stalls
  function automatic int unsigned model_lat(vec_t v);
    if (v.wr) return 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d;
    return 3 + v.ar_d + v.r_d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    resetn = 0;
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask

  // starts and ends at a negedge with the agent idle
  task automatic run_txn(input vec_t v);
    int ar_seen, r_seen, aw_seen, w_seen, b_seen, lat;
    bit ar_hs, aw_hs, w_hs, ok_busy, ok_stable, ok_cross, ok_wlast, done;
    logic [31:0] got_addr, got_wdata, got_rdata;
    logic [2:0]  got_size;
    logic [3:0]  got_wstrb;
    ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0; lat = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; done = 0;
    ok_busy = 1; ok_stable = 1; ok_cross = 1; ok_wlast = 1;
    got_addr = '0; got_wdata = '0; got_rdata = '0; got_size = '0; got_wstrb = '0;

    check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1; bus.req_wr = v.wr; bus.req_addr = v.addr; bus.req_size = v.size;
    bus.req_wdata = v.wdata; bus.req_wstrb = v.wstrb;
    @(posedge clk);
    @(negedge clk);
    if (v.hold_req) begin
      bus.req_wr = !v.wr; bus.req_addr = 32'h1FAF_0FF0; bus.req_wdata = $urandom;
    end else begin
      bus.req_valid = 0;
    end

    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      if (bus.resp_valid) begin
        done = 1; lat = cyc; got_rdata = bus.resp_rdata;
      end else if (!bus.busy || bus.req_ready) ok_busy = 0;
      if (bus.wlast !== bus.wvalid) ok_wlast = 0;
      if (v.wr ? (bus.arvalid || bus.rready) : (bus.awvalid || bus.wvalid || bus.bready))
        ok_cross = 0;

      if (bus.arvalid) begin
        if (ar_hs) ok_stable = 0;
        if (ar_seen == 0) begin got_addr = bus.araddr; got_size = bus.arsize; end
        else if (bus.araddr !== got_addr || bus.arsize !== got_size) ok_stable = 0;
        bus.arready = (ar_seen == int'(v.ar_d));
        if (bus.arready) ar_hs = 1;
        ar_seen++;
      end else begin
        if (ar_seen > 0 && !ar_hs) ok_stable = 0;
        bus.arready = 0;
      end

      if (bus.awvalid) begin
        if (aw_hs) ok_stable = 0;
        if (aw_seen == 0) begin got_addr = bus.awaddr; got_size = bus.awsize; end
        else if (bus.awaddr !== got_addr || bus.awsize !== got_size) ok_stable = 0;
        bus.awready = (aw_seen == int'(v.aw_d));
        if (bus.awready) aw_hs = 1;
        aw_seen++;
      end else begin
        if (aw_seen > 0 && !aw_hs) ok_stable = 0;
        bus.awready = 0;
      end

      if (bus.wvalid) begin
        if (w_hs) ok_stable = 0;
        if (w_seen == 0) begin got_wdata = bus.wdata; got_wstrb = bus.wstrb; end
        else if (bus.wdata !== got_wdata || bus.wstrb !== got_wstrb) ok_stable = 0;
        bus.wready = (w_seen == int'(v.w_d));
        if (bus.wready) w_hs = 1;
        w_seen++;
      end else begin
        if (w_seen > 0 && !w_hs) ok_stable = 0;
        bus.wready = 0;
      end

      if (bus.rready) begin
        bus.rvalid = (r_seen == int'(v.r_d));
        r_seen++;
      end else bus.rvalid = v.noise;
      bus.rdata = (bus.rvalid && bus.rready) ? v.rdata : $urandom;

      if (bus.bready) begin
        bus.bvalid = (b_seen == int'(v.b_d));
        b_seen++;
      end else bus.bvalid = v.noise;

      if (!done) @(negedge clk);
    end

    check("resp_seen", 32'(done), 32'd1);
    if (!done) begin
      apply_reset();
    end else begin
      check("latency", 32'(lat), 32'(v.exp_lat));
      check("phys_addr", got_addr, v.exp_addr);
      check("axsize", 32'(got_size), 32'({1'b0, v.size}));
      if (v.wr) begin
        check("wdata", got_wdata, v.wdata);
        check("wstrb", 32'(got_wstrb), 32'(v.wstrb));
      end else begin
        check("resp_rdata", got_rdata, v.rdata);
      end
      check("busy_while_inflight", 32'(ok_busy), 32'd1);
      check("channel_stable", 32'(ok_stable), 32'd1);
      check("no_wrong_channel", 32'(ok_cross), 32'd1);
      check("wlast_eq_wvalid", 32'(ok_wlast), 32'd1);
      bus.arready = 0; bus.awready = 0; bus.wready = 0; bus.rvalid = 0; bus.bvalid = 0;
      @(negedge clk);
      check("resp_single_pulse", 32'(bus.resp_valid), 32'd0);
      check("req_ready_after_resp", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    checks = 0;
    errors = 0;
    idle_inputs();
    resetn = 1;
    #2 resetn = 0;
    #1;
    check("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_aw_w_valid", 32'({bus.awvalid, bus.wvalid}), 32'd0);
    check("rst_rready_bready", 32'({bus.rready, bus.bready}), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_araddr", bus.araddr, 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);

    //          wr addr           sz wdata          strb     rdata          ar r aw w b  nz hold exp_addr       lat
    tbl[0] = mk(0, 32'hBFAF_F020, 2, 32'h0,         4'h0,    32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 32'h1FAF_F020, 3);
    tbl[1] = mk(1, 32'hBFAF_8000, 0, 32'h00AB_0000, 4'b0100, 32'h0,         0, 0, 3, 0, 2, 0, 0, 32'h1FAF_8000, 8);
    tbl[2] = mk(0, 32'h9FAF_0010, 2, 32'h0,         4'h0,    32'h5555_AAAA, 5, 0, 0, 0, 0, 0, 1, 32'h1FAF_0010, 8);
    tbl[3] = mk(1, 32'hBFAF_0000, 2, 32'hDEAD_BEEF, 4'hF,    32'h0,         0, 0, 0, 0, 0, 0, 0, 32'h1FAF_0000, 3);
    tbl[4] = mk(0, 32'hBFAF_0004, 2, 32'h0,         4'h0,    32'h0BAD_F00D, 0, 0, 0, 0, 0, 0, 0, 32'h1FAF_0004, 3);
    tbl[5] = mk(0, 32'h1FAF_0040, 1, 32'h0,         4'h0,    32'h0000_1357, 0, 2, 0, 0, 0, 1, 0, 32'h1FAF_0040, 5);
    tbl[6] = mk(1, 32'hA000_0008, 1, 32'h1234_0000, 4'b1100, 32'h0,         0, 0, 0, 2, 1, 1, 0, 32'h0000_0008, 6);
    tbl[7] = mk(1, 32'hC000_1000, 2, 32'h0102_0304, 4'hF,    32'h0,         0, 0, 1, 1, 0, 0, 1, 32'hC000_1000, 4);
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // reset while the read waits for data
    bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = 32'hBFAF_0100; bus.req_size = 2;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    check("rstseq_arvalid", 32'(bus.arvalid), 32'd1);
    bus.arready = 1;
    @(negedge clk);
    bus.arready = 0;
    check("rstseq_rready", 32'(bus.rready), 32'd1);
    #2 resetn = 0;
    #1;
    check("rstseq_valids", 32'({bus.arvalid, bus.awvalid, bus.wvalid}), 32'd0);
    check("rstseq_readies", 32'({bus.rready, bus.bready}), 32'd0);
    check("rstseq_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstseq_busy", 32'(bus.busy), 32'd0);
    check("rstseq_araddr", bus.araddr, 32'd0);
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    run_txn(mk(0, 32'hBFAF_0200, 2, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0,
               32'h1FAF_0200, 3));

    // random traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      v.wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: v.addr = 32'hBFAF_0000 | ($urandom & 32'h0000_FFFC);
        1: v.addr = 32'h9FAF_0000 | ($urandom & 32'h0000_FFFC);
        2: v.addr = 32'h1FAF_0000 | ($urandom & 32'h0000_FFFC);
        default: v.addr = $urandom;
      endcase
      v.size = 2'($urandom_range(0, 2));
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(0, 15));
      v.rdata = $urandom;
      v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
      v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
      v.noise = 1'($urandom_range(0, 1));
      v.hold_req = 1'($urandom_range(0, 1));
      v.exp_addr = model_phys(v.addr);
      v.exp_lat = model_lat(v);
      run_txn(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uncache_agent.md
# uncache_agent

Executes single-beat uncached loads and stores for the MEM stage over an AXI3/AXI4-style master port. Sits directly downstream of the address-attribute check. When that check flags an access as uncached (physical region 0x1FAF_xxxx), MEM hands the access here instead of the D-cache. The pipeline stalls on `busy` until the access completes.

## Interface

Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. The strobe is `DATA_W/8` bits.

Ports (name, direction, width, meaning):
- `clk` — in, 1 — single clock; all logic is on the rising edge.
- `resetn` — in, 1 — reset, asynchronous, active-low.
- `req_valid` — in, 1 — an uncached access is presented.
- `req_ready` — out, 1 — the agent is idle and accepts a request.
- `req_wr` — in, 1 — 1 = store, 0 = load.
- `req_addr` — in, ADDR_W — virtual address.
- `req_size` — in, 2 — 0 = byte, 1 = half, 2 = word.
- `req_wdata` — in, DATA_W — store data, already lane-aligned.
- `req_wstrb` — in, DATA_W/8 — store byte enables.
- `busy` — out, 1 — an access is in flight; drives the MEM stall.
- `resp_valid` — out, 1 — one-cycle completion pulse.
- `resp_rdata` — out, DATA_W — load data; valid only with `resp_valid`.
- Read address channel: `arvalid` out 1, `araddr` out ADDR_W, `arsize` out 3, `arready` in 1.
- Read data channel: `rvalid` in 1, `rdata` in DATA_W, `rready` out 1.
- Write address channel: `awvalid` out 1, `awaddr` out ADDR_W, `awsize` out 3, `awready` in 1.
- Write data channel: `wvalid` out 1, `wdata` out DATA_W, `wstrb` out DATA_W/8, `wlast` out 1, `wready` in 1.
- Write response channel: `bvalid` in 1, `bready` out 1.

## Operation

- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, register wr, size, wdata, wstrb and the physical address.
  - Go to RD_ADDR if `req_wr` = 0, otherwise go to WR_REQ.
- Address translation: if `req_addr[31:30]` == 2'b10 (kseg0/kseg1), the physical address is `{3'b000, req_addr[28:0]}`; otherwise the address passes through unchanged.
- `arsize` and `awsize` = `{1'b0, size}`. Burst length is always 1.
- RD_ADDR: `arvalid` = 1. On `arready`, go to RD_DATA.
- RD_DATA: `rready` = 1. On `rvalid`, latch `rdata` into `resp_rdata` and go to DONE.
- WR_REQ:
  - `awvalid` is high until the AW handshake; `wvalid` is high until the W handshake. The two are tracked independently with flags `aw_done` and `w_done`.
  - `wlast` = `wvalid`.
  - When both handshakes are complete (same cycle or different cycles), go to WR_RESP.
- WR_RESP: `bready` = 1. On `bvalid`, go to DONE.
- DONE: `resp_valid` = 1 for exactly one cycle, then go to IDLE.
- `rresp`/`bresp` are not examined. Error responses complete normally.
- `busy` = (state != IDLE). `req_ready` = (state == IDLE).
- All AXI outputs are driven from registered state and captured data, never combinationally from `req_*`.
- Channel outputs stay stable while valid is high and ready is low.

## Timing

- Reset: on `resetn` low, the FSM goes to IDLE asynchronously.
  - All valid/ready outputs, `resp_valid`, `aw_done` and `w_done` are 0. `resp_rdata` is 0.
  - Address and data outputs are 0.
  - `req_ready` is 1 once reset is released.
- Reset mid-transaction abandons the bus transfer; the whole system resets together.
- Accept edge = cycle 0.
  - Minimum read latency: `arvalid` in cycle 1, `rready` in cycle 2, `resp_valid` in cycle 3 (when `arready` and `rvalid` are immediately high).
  - Minimum write latency: `awvalid`/`wvalid` in cycle 1, `bready` in cycle 2, `resp_valid` in cycle 3.
- Each cycle of slave ready/valid delay adds one cycle.
- A new request cannot be accepted in the DONE cycle. The earliest next accept is the cycle after `resp_valid`.
- `rvalid` or `bvalid` arriving outside RD_DATA or WR_RESP is ignored (`rready`/`bready` are low then).

## Test plan

- Read to 0xBFAF_F020, `arready` = 1, `rvalid` = 1 with `rdata` = 0x1234_5678 → `araddr` = 0x1FAF_F020, `arsize` = 2, `resp_valid` in cycle 3, `resp_rdata` = 0x1234_5678.
- Store byte to 0xBFAF_8000, strb = 4'b0100, wdata = 0x00AB_0000, `awready` asserted 3 cycles after `wready` → W handshake completes first, `wvalid` drops, `awvalid` held stable until its handshake, `wlast` = 1, one `resp_valid` only after `bvalid`.
- Read with `arready` low for 5 cycles → `araddr`/`arvalid` stable throughout, `busy` = 1, `req_ready` = 0; a new `req_valid` in that window is not accepted.
- `resetn` pulled low in RD_DATA → all valids and `resp_valid` = 0 immediately, state IDLE; after release a fresh read completes normally.
- Back-to-back write then read → second request accepted the cycle after the first `resp_valid`; `awaddr` = 0x1FAF_0000, then `araddr` = 0x1FAF_0004.
